sram_arbiter: RTL and testbench

Shares one synchronous single-port SRAM between the fetch-stage instruction requester and the execute-stage data requester. Each requester uses a request/address-accept/data-return handshake. The block grants at most one request per cycle, fully pipelined, and routes the 1-cycle-latency read data back to the owner. Data requests win by default; a bounded starvation counter guarantees fetch progress.

---
 rtl/sram_arbiter.sv | 85 ++++++++
 tb/tb_sram_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one single-port synchronous SRAM between the fetch
// (inst) and execute (data) requesters. Data wins by default; a saturating
// starvation counter force-grants fetch after STARVE_LIMIT consecutive losses.
//
// resp_owner | meaning
// -----------+-----------------------------------------------
// OWN_NONE   | no access was granted last cycle
// OWN_INST   | last cycle's access belongs to fetch
// OWN_DATA   | last cycle's access belongs to execute
module sram_arbiter #(
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        sram_en,
  output logic [3:0]  sram_wen,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_INST = 2'b01,
    OWN_DATA = 2'b10
  } resp_owner_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  resp_owner_t r_resp_owner;
  logic [3:0]  r_starve_cnt;
  logic        w_force_inst;
  logic        w_grant_d;
  logic        w_grant_i;

  // Arbitration: data wins unless fetch has hit the starvation limit; reset blocks all grants.
  always_comb begin
    w_force_inst = inst_req && (r_starve_cnt == LIMIT);
    w_grant_d    = !reset && data_req && !w_force_inst;
    w_grant_i    = !reset && inst_req && !w_grant_d;
  end

  assign inst_addr_ok = w_grant_i;
  assign data_addr_ok = w_grant_d;

  assign sram_en    = w_grant_i | w_grant_d;
  assign sram_addr  = w_grant_d ? data_addr : inst_addr;
  assign sram_wdata = data_wdata;
  assign sram_wen   = (w_grant_d && data_wr) ? data_wstrb : 4'b0000;

  // Read data is shared; the data_ok strobes say whose it is.
  assign inst_rdata   = sram_rdata;
  assign data_rdata   = sram_rdata;
  assign inst_data_ok = r_resp_owner[0];
  assign data_data_ok = r_resp_owner[1];

  // Response owner follows the grant with one cycle of latency; starve counter tracks fetch losses.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_resp_owner <= OWN_NONE;
      r_starve_cnt <= 4'd0;
    end else begin
      r_resp_owner <= resp_owner_t'({w_grant_d, w_grant_i});
      if (!inst_req || w_grant_i) begin
        r_starve_cnt <= 4'd0;
      end else if (w_grant_d && (r_starve_cnt != LIMIT)) begin
        r_starve_cnt <= r_starve_cnt + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Testbench for sram_arbiter: a behavioural SRAM on the DUT pins plus a
// transaction-level reference (expected grants, reference memory, pending response).
module tb_sram_arbiter;
  localparam int LIMIT = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        sram_en;
  logic [3:0]  sram_wen;
  logic [31:0] sram_addr, sram_wdata;
  logic [31:0] sram_rdata = 32'h0;

  always #5 clk = ~clk;

  sram_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .sram_en(sram_en), .sram_wen(sram_wen), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  // Behavioural SRAM driven purely by the DUT's SRAM pins: read-before-write, 1-cycle latency.
  logic [31:0] sram_mem [16];
  always @(posedge clk) begin
    if (sram_en) begin
      sram_rdata <= sram_mem[sram_addr[5:2]];
      for (int b = 0; b < 4; b++)
        if (sram_wen[b]) sram_mem[sram_addr[5:2]][8*b +: 8] <= sram_wdata[8*b +: 8];
    end
  end

  // Reference state at the requester level.
  logic [31:0] ref_mem [16];
  int          losses;        // consecutive cycles fetch requested and lost
  int          pend_owner;    // 0 none, 1 inst, 2 data
  bit          pend_is_load;
  logic [31:0] pend_rdata;

  int          n_checks = 0;
  int          n_fail   = 0;

  logic [72:0] exp_ctl, obs_ctl;
  bit          exp_rd_valid;
  logic [31:0] exp_rdata, obs_rdata;
  bit          eg_i, eg_d;

  // One clock of stimulus; fills exp_*/obs_* for the calling test to compare.
  task automatic do_cycle(input bit rst, input bit ir, input logic [31:0] ia,
                          input bit dr, input bit dw, input logic [3:0] ws,
                          input logic [31:0] da, input logic [31:0] dwd);
    int idx;
    reset = rst; inst_req = ir; inst_addr = ia;
    data_req = dr; data_wr = dw; data_wstrb = ws; data_addr = da; data_wdata = dwd;
    eg_i = 1'b0; eg_d = 1'b0;
    if (!rst) begin
      if (ir && dr) begin
        if (losses >= LIMIT) eg_i = 1'b1; else eg_d = 1'b1;
      end else begin
        eg_i = ir; eg_d = dr;
      end
    end
    exp_ctl = {eg_i, eg_d, eg_i | eg_d, (eg_d && dw) ? ws : 4'b0000,
               eg_d ? da : ia, dwd, pend_owner == 1, pend_owner == 2};
    exp_rd_valid = (pend_owner == 1) || (pend_owner == 2 && pend_is_load);
    exp_rdata = pend_rdata;
    @(negedge clk);
    obs_ctl = {inst_addr_ok, data_addr_ok, sram_en, sram_wen, sram_addr, sram_wdata,
               inst_data_ok, data_data_ok};
    obs_rdata = (pend_owner == 1) ? inst_rdata : data_rdata;
    @(posedge clk); #1;
    pend_owner = eg_d ? 2 : (eg_i ? 1 : 0);
    pend_is_load = eg_d && !dw;
    idx = eg_d ? int'(da[5:2]) : int'(ia[5:2]);
    pend_rdata = ref_mem[idx];
    if (eg_d && dw)
      for (int b = 0; b < 4; b++)
        if (ws[b]) ref_mem[idx][8*b +: 8] = dwd[8*b +: 8];
    if (rst || !ir || eg_i) losses = 0;
    else if (eg_d && losses < LIMIT) losses = losses + 1;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      do_cycle(1, 1, 32'h40, 1, 1, 4'hF, 32'h44, 32'h12345678);
      n_checks++;
      if (obs_ctl !== exp_ctl) begin
        n_fail++; $display("FAIL reset c%0d ctl got=%h exp=%h", k, obs_ctl, exp_ctl);
      end
      n_checks++;
      if (sram_en !== 1'b0 || inst_addr_ok !== 1'b0 || data_addr_ok !== 1'b0) begin
        n_fail++; $display("FAIL reset_grant c%0d got en=%b iok=%b dok=%b exp 0", k, sram_en, inst_addr_ok, data_addr_ok);
      end
    end
  endtask

  task automatic test_inst_only();
    sram_mem[0] = 32'h1C000001; ref_mem[0] = 32'h1C000001;
    for (int k = 0; k < 4; k++) begin
      do_cycle(0, k < 3, 32'h1C000000, 0, 0, 4'h0, 32'h0, 32'h0);
      n_checks++;
      if (obs_ctl !== exp_ctl) begin
        n_fail++; $display("FAIL inst_only c%0d ctl got=%h exp=%h", k, obs_ctl, exp_ctl);
      end
      if (exp_rd_valid) begin
        n_checks++;
        if (obs_rdata !== exp_rdata) begin
          n_fail++; $display("FAIL inst_only c%0d rdata got=%h exp=%h", k, obs_rdata, exp_rdata);
        end
      end
      if (k == 1) begin
        n_checks++;
        if (obs_ctl[1] !== 1'b1 || obs_rdata !== 32'h1C000001) begin
          n_fail++; $display("FAIL inst_first_resp got ok=%b rdata=%h exp ok=1 rdata=1c000001", obs_ctl[1], obs_rdata);
        end
      end
    end
  endtask

  task automatic test_store_load();
    sram_mem[0] = 32'h11223344; ref_mem[0] = 32'h11223344;
    for (int k = 0; k < 3; k++) begin
      do_cycle(0, 0, 32'h0, k < 2, k == 0, 4'b0011, 32'h100, 32'hAABBCCDD);
      n_checks++;
      if (obs_ctl !== exp_ctl) begin
        n_fail++; $display("FAIL store_load c%0d ctl got=%h exp=%h", k, obs_ctl, exp_ctl);
      end
      if (exp_rd_valid) begin
        n_checks++;
        if (obs_rdata !== exp_rdata) begin
          n_fail++; $display("FAIL store_load c%0d rdata got=%h exp=%h", k, obs_rdata, exp_rdata);
        end
      end
      if (k == 2) begin
        n_checks++;
        if (obs_ctl[0] !== 1'b1 || obs_rdata !== 32'h1122CCDD) begin
          n_fail++; $display("FAIL load_after_store got ok=%b rdata=%h exp ok=1 rdata=1122ccdd", obs_ctl[0], obs_rdata);
        end
      end
    end
  endtask

  // Both requesters held high for ncyc cycles; fetch wins only every (LIMIT+1)th.
  task automatic test_contention(input string name, input int ncyc);
    for (int k = 0; k < ncyc; k++) begin
      do_cycle(0, 1, 32'h1C000000 + 32'(4 * (k % 16)), 1, 0, 4'h0,
               32'h200 + 32'(4 * ((k + 5) % 16)), 32'h0);
      n_checks++;
      if (obs_ctl !== exp_ctl) begin
        n_fail++; $display("FAIL %s c%0d ctl got=%h exp=%h", name, k, obs_ctl, exp_ctl);
      end
      if (exp_rd_valid) begin
        n_checks++;
        if (obs_rdata !== exp_rdata) begin
          n_fail++; $display("FAIL %s c%0d rdata got=%h exp=%h", name, k, obs_rdata, exp_rdata);
        end
      end
      n_checks++;
      if (obs_ctl[72] !== ((k % (LIMIT + 1)) == LIMIT)) begin
        n_fail++; $display("FAIL %s_pattern c%0d inst_addr_ok got=%b exp=%b", name, k, obs_ctl[72], (k % (LIMIT + 1)) == LIMIT);
      end
    end
  endtask

  task automatic test_zero_strobe();
    for (int k = 0; k < 2; k++) begin
      do_cycle(0, 0, 32'h0, k == 0, 1, 4'b0000, 32'h8, 32'hDEADBEEF);
      n_checks++;
      if (obs_ctl !== exp_ctl) begin
        n_fail++; $display("FAIL zero_strobe c%0d ctl got=%h exp=%h", k, obs_ctl, exp_ctl);
      end
    end
  endtask

  // Build up starvation, interrupt it (reset or dropped req), then re-check the full pattern.
  task automatic test_interrupt(input string name, input bit use_reset);
    for (int k = 0; k < 3; k++) begin
      if (k < 2) do_cycle(0, 1, 32'h4, 1, 0, 4'h0, 32'h8, 32'h0);
      else       do_cycle(use_reset, !use_reset ? 1'b0 : 1'b1, 32'h4, 1, 0, 4'h0, 32'h8, 32'h0);
      n_checks++;
      if (obs_ctl !== exp_ctl) begin
        n_fail++; $display("FAIL %s c%0d ctl got=%h exp=%h", name, k, obs_ctl, exp_ctl);
      end
    end
    test_contention({name, "_after"}, LIMIT + 1);
  endtask

  task automatic test_random(input int ncyc);
    for (int k = 0; k < ncyc; k++) begin
      do_cycle($urandom_range(0, 49) == 0, 1'($urandom), {26'($urandom), 4'($urandom), 2'b00},
               1'($urandom), 1'($urandom), 4'($urandom),
               {26'($urandom), 4'($urandom), 2'b00}, $urandom);
      n_checks++;
      if (obs_ctl !== exp_ctl) begin
        n_fail++; $display("FAIL random c%0d ctl got=%h exp=%h", k, obs_ctl, exp_ctl);
      end
      if (exp_rd_valid) begin
        n_checks++;
        if (obs_rdata !== exp_rdata) begin
          n_fail++; $display("FAIL random c%0d rdata got=%h exp=%h", k, obs_rdata, exp_rdata);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      sram_mem[i] = 32'hA5000000 + 32'(i);
      ref_mem[i]  = 32'hA5000000 + 32'(i);
    end
    losses = 0; pend_owner = 0; pend_is_load = 1'b0; pend_rdata = 32'h0;
    reset = 1'b1; inst_req = 1'b0; inst_addr = 32'h0; data_req = 1'b0; data_wr = 1'b0;
    data_wstrb = 4'h0; data_addr = 32'h0; data_wdata = 32'h0;
    @(posedge clk); #1;
    test_reset();
    test_inst_only();
    test_store_load();
    do_cycle(0, 0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
    test_contention("contention", 2 * (LIMIT + 1));
    test_zero_strobe();
    test_interrupt("reset_mid", 1'b1);
    do_cycle(0, 0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
    test_interrupt("drop_req", 1'b0);
    test_random(400);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
